dt_sti_loader: RTL and testbench

- Initialisation stage directly upstream of the distance-transform forward/backward passes.
- Reads the packed 128x128 binary source image from the 1024x16 sti ROM and writes one byte per pixel into the 16384x8 res RAM.
- Object pixels are written as OBJ_VAL and background pixels as 8'h00, so the DT passes start from a fully initialised result map.
- Also reports the number of object pixels found.

---
 rtl/dt_sti_loader.sv | 118 +++++++++++
 tb/tb_dt_sti_loader.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/dt_sti_loader.sv
// dt_sti_loader: initialises the distance-transform result map.
// Reads the packed 128x128 binary image (1024 x 16-bit ROM words, bit 15 is the
// leftmost pixel) and writes one byte per pixel into the 16384 x 8 result RAM:
// OBJ_VAL for object pixels, BG_VAL for background. Counts object pixels.
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-low reset
//   start             one-cycle load request, honoured only in IDLE
//   sti_rd, sti_addr  ROM read enable / word address (data arrives on negedge)
//   sti_di            ROM read data
//   res_wr, res_addr  RAM write enable / byte address {word, pixel}
//   res_do            RAM write data
//   busy              high from first FETCH through last WRITE
//   done              one-cycle pulse after the final write
//   obj_cnt           object pixels written in the current/last load
module dt_sti_loader #(
  parameter logic [7:0] OBJ_VAL = 8'h01,
  parameter logic [7:0] BG_VAL  = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        sti_rd,
  output logic [9:0]  sti_addr,
  input  logic [15:0] sti_di,
  output logic        res_wr,
  output logic [13:0] res_addr,
  output logic [7:0]  res_do,
  output logic        busy,
  output logic        done,
  output logic [14:0] obj_cnt
);

  localparam int unsigned AW = 10;
  localparam int unsigned PW = 4;
  localparam logic [AW-1:0] LAST_WORD = AW'(1023);
  localparam logic [PW-1:0] LAST_PIX  = PW'(15);

  typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

  state_t        state;
  logic [AW-1:0] word_addr;
  logic [PW-1:0] pix;
  logic [15:0]   shreg;

  // Outputs are registered, so each edge loads the values for the state being
  // entered: the FETCH closing edge already presents pixel 0 of the word, and
  // the remaining pixels are shifted out of shreg MSB-first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      word_addr <= '0;
      pix       <= '0;
      shreg     <= '0;
      sti_rd    <= 1'b0;
      sti_addr  <= '0;
      res_wr    <= 1'b0;
      res_addr  <= '0;
      res_do    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      obj_cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= FETCH;
            word_addr <= '0;
            obj_cnt   <= '0;
            sti_rd    <= 1'b1;
            sti_addr  <= '0;
            busy      <= 1'b1;
          end
        end

        FETCH: begin
          state    <= WRITE;
          sti_rd   <= 1'b0;
          pix      <= '0;
          shreg    <= {sti_di[14:0], 1'b0};
          res_wr   <= 1'b1;
          res_addr <= {word_addr, PW'(0)};
          res_do   <= sti_di[15] ? OBJ_VAL : BG_VAL;
          if (sti_di[15]) obj_cnt <= obj_cnt + 15'd1;
        end

        WRITE: begin
          if (pix == LAST_PIX) begin
            res_wr <= 1'b0;
            if (word_addr == LAST_WORD) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state     <= FETCH;
              word_addr <= word_addr + AW'(1);
              sti_addr  <= word_addr + AW'(1);
              sti_rd    <= 1'b1;
            end
          end else begin
            pix      <= pix + PW'(1);
            res_addr <= {word_addr, pix + PW'(1)};
            res_do   <= shreg[15] ? OBJ_VAL : BG_VAL;
            shreg    <= {shreg[14:0], 1'b0};
            if (shreg[15]) obj_cnt <= obj_cnt + 15'd1;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dt_sti_loader.sv
// Directed testbench for dt_sti_loader with behavioural ROM and RAM models.
module tb_dt_sti_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic        sti_rd;
  logic [9:0]  sti_addr;
  logic [15:0] sti_di;
  logic        res_wr;
  logic [13:0] res_addr;
  logic [7:0]  res_do;
  logic        busy;
  logic        done;
  logic [14:0] obj_cnt;

  int checks = 0;
  int errors = 0;

  logic [15:0] rom [1024];
  logic [7:0]  ram [16384];

  // monitor state
  int          coll = 0;
  int          ord_err = 0;
  int          wr_cnt = 0;
  logic [13:0] exp_addr = '0;

  dt_sti_loader dut (
    .clk(clk), .reset(reset), .start(start),
    .sti_rd(sti_rd), .sti_addr(sti_addr), .sti_di(sti_di),
    .res_wr(res_wr), .res_addr(res_addr), .res_do(res_do),
    .busy(busy), .done(done), .obj_cnt(obj_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM: data appears on the negedge of the read cycle
  always @(negedge clk) if (sti_rd) sti_di <= rom[sti_addr];

  // RAM: write on posedge
  always @(posedge clk) if (res_wr) ram[res_addr] <= res_do;

  // Bus monitor: read/write exclusion and in-order write addresses per load
  always @(negedge clk) begin
    if (sti_rd && res_wr) coll <= coll + 1;
    if (sti_rd && sti_addr == 10'd0) begin
      exp_addr <= '0;
      wr_cnt   <= 0;
    end
    if (res_wr) begin
      if (res_addr !== exp_addr) ord_err <= ord_err + 1;
      exp_addr <= exp_addr + 14'd1;
      wr_cnt   <= wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ram_errs();
    int e = 0;
    logic [15:0] w;
    for (int a = 0; a < 16384; a++) begin
      w = rom[a >> 4];
      if (ram[a] !== (w[15 - (a & 15)] ? 8'h01 : 8'h00)) e++;
    end
    return e;
  endfunction

  function automatic int rom_pop();
    int p = 0;
    for (int i = 0; i < 1024; i++) p += $countones(rom[i]);
    return p;
  endfunction

  // Pulse start, optionally re-pulse it at cycle 'repulse', wait for done.
  // lat is the cycle (1 = first FETCH) in which done is seen; 0 on timeout.
  task automatic run_load(input int repulse, input bit poke_done,
                          output int lat, output logic busy_mid);
    int n = 0;
    lat = 0;
    busy_mid = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    n = 1;
    start = 1'b0;
    while (lat == 0 && n < 20000) begin
      if (n == 100) busy_mid = busy;
      if (done) lat = n;
      else begin
        @(negedge clk);
        n++;
        start = (n == repulse);
      end
    end
    if (poke_done) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  int          lat;
  logic        bm;
  int          pop_a;
  logic [14:0] cnt_a;
  int          z;

  initial begin
    start = 1'b0;
    reset = 1'b0;
    for (int a = 0; a < 16384; a++) ram[a] = 8'hAA;
    #3;
    check("reset_outputs", 64'({sti_rd, sti_addr, res_wr, res_addr, res_do, busy, done, obj_cnt}), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // 1: all-zero image
    for (int i = 0; i < 1024; i++) rom[i] = 16'h0000;
    run_load(0, 1'b0, lat, bm);
    check("zero_latency", 64'(lat), 64'd17409);
    check("zero_obj_cnt", 64'(obj_cnt), 64'd0);
    check("zero_wr_count", 64'(wr_cnt), 64'd16384);
    check("zero_last_addr", 64'(res_addr), 64'd16383);
    check("zero_ram", 64'(ram_errs()), 64'd0);
    check("zero_busy_mid", 64'(bm), 64'd1);

    // 2: all-ones image; start poked while in DONE must be ignored
    for (int i = 0; i < 1024; i++) rom[i] = 16'hFFFF;
    run_load(0, 1'b1, lat, bm);
    check("ones_latency", 64'(lat), 64'd17409);
    check("ones_done_width", 64'(done), 64'd0);
    check("ones_obj_cnt", 64'(obj_cnt), 64'd16384);
    check("ones_ram", 64'(ram_errs()), 64'd0);
    repeat (3) @(negedge clk);
    check("ones_start_in_done_ignored", 64'({busy, sti_rd}), 64'd0);
    check("ones_obj_cnt_held", 64'(obj_cnt), 64'd16384);

    // 3: random image A with word 0 = 8001 for bit-order
    for (int i = 0; i < 1024; i++) rom[i] = 16'($urandom);
    rom[0] = 16'h8001;
    pop_a = rom_pop();
    run_load(0, 1'b0, lat, bm);
    cnt_a = obj_cnt;
    check("randA_latency", 64'(lat), 64'd17409);
    check("randA_obj_cnt", 64'(obj_cnt), 64'(pop_a));
    check("randA_ram", 64'(ram_errs()), 64'd0);
    check("bitorder_px0", 64'(ram[0]), 64'h01);
    check("bitorder_px15", 64'(ram[15]), 64'h01);
    z = 0;
    for (int a = 1; a < 15; a++) if (ram[a] !== 8'h00) z++;
    check("bitorder_px1_14", 64'(z), 64'd0);

    // 4: abort a load of the inverse image by reset around cycle 3000
    for (int i = 0; i < 1024; i++) rom[i] = ~rom[i];
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2999) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_outputs_zero", 64'({sti_rd, sti_addr, res_wr, res_addr, res_do, busy, done, obj_cnt}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // 5: reload image A from scratch, with start re-pulsed at cycle 5000
    for (int i = 0; i < 1024; i++) rom[i] = ~rom[i];
    run_load(5000, 1'b0, lat, bm);
    check("repulse_latency", 64'(lat), 64'd17409);
    check("repulse_obj_cnt", 64'(obj_cnt), 64'(cnt_a));
    check("repulse_ram", 64'(ram_errs()), 64'd0);
    check("repulse_busy_mid", 64'(bm), 64'd1);
    check("repulse_wr_count", 64'(wr_cnt), 64'd16384);

    check("rd_wr_exclusive", 64'(coll), 64'd0);
    check("write_order", 64'(ord_err), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
